// File: rtl/alarm_time_editor.sv
// alarm_time_editor: debounced three-button editor for the BCD current-time preset and BCD alarm time.
module alarm_time_editor #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic [3:0] hourdec_set,
    output logic [3:0] hourone_set,
    output logic [3:0] mindec_set,
    output logic [3:0] minone_set,
    output logic       time_load,
    output logic [3:0] hourdec_bud,
    output logic [3:0] hourone_bud,
    output logic [3:0] mindec_bud,
    output logic [3:0] minone_bud,
    output logic [1:0] mode,
    output logic [1:0] digit_sel
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, EDIT_TIME = 2'd1, EDIT_ALARM = 2'd2} state_t;

    // Button bit order: 0 = mode, 1 = next, 2 = inc
    logic [2:0] raw, s1_q, s2_q, acc_q, acc_d, dly_q, p_q, p_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic p_mode, p_next, p_inc;

    assign raw = {btn_inc, btn_next, btn_mode};
    assign p_mode = p_q[0];
    assign p_next = p_q[1];
    assign p_inc = p_q[2];

    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != acc_q[i]) begin
                if (cnt_q[i] == CNT_MAX) acc_d[i] = s2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        p_d = acc_q & ~dly_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            acc_q <= '0;
            dly_q <= '0;
            p_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
            acc_q <= acc_d;
            dly_q <= acc_q;
            p_q <= p_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Digit index order: 0 = hourdec, 1 = hourone, 2 = mindec, 3 = minone
    state_t state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic tl_q, tl_d;
    logic [3:0][3:0] set_q, set_d, bud_q, bud_d, cur, nxt;
    logic [3:0] hd_n;

    always_comb begin
        cur = (state_q == EDIT_ALARM) ? bud_q : set_q;
        nxt = cur;
        hd_n = (cur[0] >= 4'd2) ? 4'd0 : cur[0] + 4'd1;
        if (sel_q == 2'd0) begin
            nxt[0] = hd_n;
            nxt[1] = (hd_n == 4'd2 && cur[1] > 4'd3) ? 4'd3 : cur[1];
        end else if (sel_q == 2'd1) begin
            nxt[1] = (cur[1] >= (cur[0] == 4'd2 ? 4'd3 : 4'd9)) ? 4'd0 : cur[1] + 4'd1;
        end else if (sel_q == 2'd2) begin
            nxt[2] = (cur[2] >= 4'd5) ? 4'd0 : cur[2] + 4'd1;
        end else begin
            nxt[3] = (cur[3] >= 4'd9) ? 4'd0 : cur[3] + 4'd1;
        end
        state_d = state_q;
        sel_d = sel_q;
        tl_d = 1'b0;
        set_d = set_q;
        bud_d = bud_q;
        if (p_mode) begin
            state_d = state_q == IDLE ? EDIT_TIME : state_q == EDIT_TIME ? EDIT_ALARM : IDLE;
            sel_d = (state_q == EDIT_ALARM) ? sel_q : 2'd0;
            tl_d = state_q == EDIT_TIME;
        end else if (p_next) begin
            sel_d = (state_q == IDLE) ? sel_q : sel_q + 2'd1;
        end else if (p_inc) begin
            set_d = (state_q == EDIT_TIME) ? nxt : set_q;
            bud_d = (state_q == EDIT_ALARM) ? nxt : bud_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q <= '0;
            tl_q <= 1'b0;
            set_q <= '0;
            bud_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            tl_q <= tl_d;
            set_q <= set_d;
            bud_q <= bud_d;
        end
    end

    assign mode = state_q;
    assign digit_sel = sel_q;
    assign time_load = tl_q;
    assign {minone_set, mindec_set, hourone_set, hourdec_set} = set_q;
    assign {minone_bud, mindec_bud, hourone_bud, hourdec_bud} = bud_q;
endmodule
